// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer: buffers {channel, 16-bit value} samples and frames each one as a paced byte packet for a flag-less UART.
// Define UART_PKT_CHECKSUM_EN to append an XOR checksum byte (5-byte packets instead of 4).
module uart_tx_packetizer #(
  parameter int CLOCK    = 50000000,
  parameter int BAUD     = 9600,
  parameter int GAP_BITS = 12,
  parameter int DEPTH    = 8,
  parameter int CHAN_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [CHAN_W-1:0]        s_chan,
  input  logic [15:0]              s_data,
  output logic [7:0]               tx_data,
  output logic                     tx_new_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int GAP     = (CLOCK / BAUD) * GAP_BITS;
  localparam int GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = CHAN_W + 16;
`ifdef UART_PKT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} state_t;

  state_t               state_q;
  logic [2:0]           idx_q;
  logic [GAP_W-1:0]     gap_q;
  logic [ENTRY_W-1:0]   pkt_q;
  logic [7:0]           tx_data_q;
  logic                 tx_new_q;

  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 push, pop;
  logic [7:0]           chan_byte, cur_byte;

  // A full FIFO refuses a push even when the head is popped in the same cycle.
  assign s_ready = (level_q != LVL_W'(DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == ST_LOAD);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // NOTE: sample storage is not reset; the pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_chan, s_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign chan_byte = 8'(pkt_q[ENTRY_W-1 -: CHAN_W]);

  always_comb begin
    cur_byte = 8'hA5;
    case (idx_q)
      3'd1:    cur_byte = chan_byte;
      3'd2:    cur_byte = pkt_q[15:8];
      3'd3:    cur_byte = pkt_q[7:0];
`ifdef UART_PKT_CHECKSUM_EN
      3'd4:    cur_byte = chan_byte ^ pkt_q[15:8] ^ pkt_q[7:0];
`endif
      default: cur_byte = 8'hA5;
    endcase
  end

  // NOTE: non-blocking assignments make every register update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      pkt_q     <= '0;
      tx_data_q <= 8'h00;
      tx_new_q  <= 1'b0;
    end else begin
      tx_new_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (level_q != '0) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          pkt_q   <= mem_q[rd_ptr_q];
          idx_q   <= '0;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          tx_data_q <= cur_byte;
          tx_new_q  <= 1'b1;
          gap_q     <= GAP_W'(GAP - 1);
          state_q   <= ST_GAP;
        end
        ST_GAP: begin
          // Pulse-to-pulse spacing is SEND (1) + GAP cycles; LOAD adds one between packets.
          if (gap_q != '0) begin
            gap_q <= gap_q - GAP_W'(1);
          end else if (idx_q != LAST_IDX) begin
            idx_q   <= idx_q + 3'd1;
            state_q <= ST_SEND;
          end else if (level_q != '0) begin
            state_q <= ST_LOAD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_new_data = tx_new_q;
  assign busy        = (state_q != ST_IDLE);
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Self-checking bench for uart_tx_packetizer: a sample-level timeline model predicts every output on every cycle.
// Packet length follows UART_PKT_CHECKSUM_EN exactly as the design does.
module tb_uart_tx_packetizer;

  localparam int CLOCK    = 1000;
  localparam int BAUD     = 100;
  localparam int GAP_BITS = 12;
  localparam int DEPTH    = 4;
  localparam int CHAN_W   = 4;
  localparam int GAP      = (CLOCK / BAUD) * GAP_BITS;
  localparam int PER      = GAP + 1;
`ifdef UART_PKT_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  s_chan = '0;
  logic [15:0] s_data = '0;
  logic [7:0]  tx_data;
  logic        tx_new_data;
  logic        busy;
  logic [2:0]  fifo_level;

  uart_tx_packetizer #(
    .CLOCK(CLOCK), .BAUD(BAUD), .GAP_BITS(GAP_BITS), .DEPTH(DEPTH), .CHAN_W(CHAN_W)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan),
    .s_data(s_data), .tx_data(tx_data), .tx_new_data(tx_new_data), .busy(busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // One accepted sample: when it was pushed, when its first byte pulses, and its framed bytes (byte k at [8k +: 8]).
  typedef struct {
    int          push_e;
    int          first_e;
    logic [39:0] bytes;
  } smp_t;

  smp_t        mq[$];
  int          cyc = 0;
  bit          started = 1'b0;
  bit          acc = 1'b0;
  int          last_push_e = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          max_lvl = 0;
  int          p_cyc[$];
  logic [7:0]  p_byte[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int last_e(smp_t s);
    return s.first_e + (NB - 1) * PER;
  endfunction

  // Samples held in the FIFO after edge n: pushed at or before n, popped (one edge before first pulse) after n.
  function automatic int level_at(int n);
    int c = 0;
    foreach (mq[i]) if (mq[i].push_e <= n && n < mq[i].first_e - 1) c++;
    return c;
  endfunction

  function automatic logic [39:0] frame(logic [3:0] ch, logic [15:0] d);
    logic [7:0] cb = {4'h0, ch};
    return {cb ^ d[15:8] ^ d[7:0], d[7:0], d[15:8], cb, 8'hA5};
  endfunction

  function automatic bit model_idle();
    return (mq.size() == 0) || (cyc >= last_e(mq[$]) + GAP);
  endfunction

  smp_t ns;
  int   nf;
  always @(posedge clk) begin
    cyc = cyc + 1;
    started = 1'b1;
    if (!rst) begin
      mq.delete();
    end else if (s_valid && level_at(cyc - 1) != DEPTH) begin
      nf = cyc + 3;
      if (mq.size() > 0 && last_e(mq[$]) + GAP + 2 > nf) nf = last_e(mq[$]) + GAP + 2;
      ns.push_e  = cyc;
      ns.first_e = nf;
      ns.bytes   = frame(s_chan, s_data);
      mq.push_back(ns);
      acc = 1'b1;
      last_push_e = cyc;
    end
  end

  bit         e_new, e_busy;
  logic [7:0] e_data;
  int         best, lvl, pt;
  always @(negedge clk) begin
    if (started) begin
      e_new  = 1'b0;
      e_busy = 1'b0;
      e_data = 8'h00;
      best   = -1;
      foreach (mq[i]) begin
        for (int k = 0; k < NB; k++) begin
          pt = mq[i].first_e + k * PER;
          if (pt == cyc) e_new = 1'b1;
          if (pt <= cyc && pt > best) begin
            best   = pt;
            e_data = mq[i].bytes[8*k +: 8];
          end
        end
        if (mq[i].first_e - 2 <= cyc && cyc < last_e(mq[i]) + GAP) e_busy = 1'b1;
      end
      lvl = level_at(cyc);
      check("tx_new_data", 32'(tx_new_data), 32'(e_new));
      check("tx_data", 32'(tx_data), 32'(e_data));
      check("busy", 32'(busy), 32'(e_busy));
      check("fifo_level", 32'(fifo_level), 32'(lvl));
      check("s_ready", 32'(s_ready), 32'(lvl != DEPTH));
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (tx_new_data) begin
        p_cyc.push_back(cyc);
        p_byte.push_back(tx_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] ch, input logic [15:0] d);
    bit got = 1'b0;
    s_chan  = ch;
    s_data  = d;
    s_valid = 1'b1;
    acc     = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      #1;
      got = acc;
    end
    s_valid = 1'b0;
    check("push_accepted", 32'(got), 32'd1);
  endtask

  task automatic wait_pulses(input int cnt, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc && p_cyc.size() < cnt; i++) @(negedge clk);
    check(name, p_cyc.size(), cnt);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && !model_idle(); i++) tick(1);
    tick(2);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic clear_pulses();
    p_cyc.delete();
    p_byte.delete();
  endtask

  logic [7:0] exp2[5];
  logic [7:0] exp6[5];
  int         t0;

  initial begin
    exp2 = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h25};
    exp6 = '{8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h50};

    // Reset held for three clocks.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_tx_new_data", 32'(tx_new_data), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single sample.
    clear_pulses();
    push(4'd3, 16'h1234);
    t0 = last_push_e;
    wait_pulses(NB, 1000, "t2_pulse_count");
    tick(GAP + 5);
    check("t2_total_pulses", p_cyc.size(), NB);
    if (p_cyc.size() > 0) check("t2_latency", p_cyc[0] - t0, 3);
    for (int k = 0; k < NB; k++) begin
      if (k < p_cyc.size()) check("t2_byte", 32'(p_byte[k]), 32'(exp2[k]));
      if (k > 0 && k < p_cyc.size()) check("t2_spacing", p_cyc[k] - p_cyc[k-1], 121);
    end
    check("t2_busy_after", 32'(busy), 32'd0);

    // FIFO full: six back-to-back pushes.
    clear_pulses();
    max_lvl = 0;
    for (int i = 0; i < 6; i++) push(4'(i + 4), 16'($urandom));
    wait_idle(6 * NB * PER + 200);
    check("t3_max_level", max_lvl, 4);
    check("t3_pulses", p_cyc.size(), 6 * NB);
    for (int i = 0; i < 6; i++)
      if (i * NB + 1 < p_byte.size()) check("t3_order", 32'(p_byte[i*NB+1]), 32'(i + 4));

    // Reset one clock after the second pulse of a packet, with more samples queued.
    clear_pulses();
    push(4'd7, 16'h0F0F);
    push(4'd8, 16'h1111);
    push(4'd9, 16'h2222);
    wait_pulses(2, 500, "t5_two_pulses");
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(400);
    check("t5_no_more_pulses", p_cyc.size(), 2);
    check("t5_fifo_level", 32'(fifo_level), 32'd0);
    check("t5_tx_data", 32'(tx_data), 32'h00);
    check("t5_busy", 32'(busy), 32'd0);

    // Sample arriving during the second byte's gap.
    clear_pulses();
    push(4'd3, 16'h1234);
    wait_pulses(2, 500, "t6_two_pulses");
    tick(20);
    push(4'd1, 16'hBEEF);
    wait_pulses(2 * NB, 2000, "t6_pulse_count");
    tick(GAP + 5);
    if (p_cyc.size() > NB) check("t6_gap", p_cyc[NB] - p_cyc[NB-1], 122);
    for (int k = 0; k < NB; k++)
      if (NB + k < p_byte.size()) check("t6_byte", 32'(p_byte[NB+k]), 32'(exp6[k]));

    // Randomized traffic, judged cycle by cycle against the timeline model.
    clear_pulses();
    for (int i = 0; i < 30; i++) begin
      tick($urandom_range(1, 250));
      push(4'($urandom), 16'($urandom));
    end
    wait_idle(30 * NB * PER + 500);
    check("rand_pulses", p_cyc.size(), 30 * NB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
